// File: rtl/arb_pkg.sv
// Shared sizing for the four-way round-robin arbiter.
// No logic, types and constants only.
// Imported by rr_pick4 and rr_arb_4x_nbit.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef logic [IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/mux_4x_nbit.sv
// Generic 4:1 word mux, selection by a 2-bit index.
// Latency: purely combinational.
// Backpressure: none, no flow control.
module mux_4x_nbit #(
  parameter int BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] in_a,
  input  logic [BUS_WIDTH-1:0] in_b,
  input  logic [BUS_WIDTH-1:0] in_c,
  input  logic [BUS_WIDTH-1:0] in_d,
  input  logic [1:0]           sel,
  output logic [BUS_WIDTH-1:0] out_y
);

  // Route the selected input word to the output.
  always_comb begin
    out_y = in_a;
    case (sel)
      2'd0:    out_y = in_a;
      2'd1:    out_y = in_b;
      2'd2:    out_y = in_c;
      default: out_y = in_d;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Round-robin picker: first set request at or after ptr, wrapping mod 4.
// Latency: purely combinational.
// Backpressure: none, the caller gates the grant with its own load enable.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output req_idx_t           gnt,
  output logic               any
);

  req_idx_t idx;

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    gnt = ptr;
    idx = ptr;
    any = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + req_idx_t'(k);
      if (req[idx]) begin
        gnt = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_4x_nbit.sv
// Four-requester round-robin arbiter with a registered output word and source index.
// Latency: a word accepted on one edge is on out_data right after that edge.
// Backpressure: out_valid & !out_ready holds the output and drops every in_ready bit.
// Optional burst lock under RR_ARB_BURST_LOCK_EN (adds in_last; grant sticks until a last word).
module rr_arb_4x_nbit
  import arb_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           in_valid,
  input  logic [BUS_WIDTH-1:0] in_data_a,
  input  logic [BUS_WIDTH-1:0] in_data_b,
  input  logic [BUS_WIDTH-1:0] in_data_c,
  input  logic [BUS_WIDTH-1:0] in_data_d,
`ifdef RR_ARB_BURST_LOCK_EN
  input  logic [3:0]           in_last,
`endif
  output logic [3:0]           in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [1:0]           out_src
);

  req_idx_t             ptr;
  req_idx_t             gnt;
  logic                 any_req;
  logic                 load_en;
  logic                 xfer;
  logic [3:0]           pick_req;
  logic [BUS_WIDTH-1:0] sel_data;

`ifdef RR_ARB_BURST_LOCK_EN
  logic     lock_vld;
  req_idx_t lock_idx;
`endif

  assign load_en = !out_valid || out_ready;

  // Requests seen by the picker; a held burst masks everyone but its owner.
  always_comb begin
    pick_req = in_valid;
`ifdef RR_ARB_BURST_LOCK_EN
    if (lock_vld) begin
      pick_req = in_valid & (4'b0001 << lock_idx);
    end
`endif
  end

  rr_pick4 u_pick (
    .req (pick_req),
    .ptr (ptr),
    .gnt (gnt),
    .any (any_req)
  );

  mux_4x_nbit #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_mux (
    .in_a  (in_data_a),
    .in_b  (in_data_b),
    .in_c  (in_data_c),
    .in_d  (in_data_d),
    .sel   (gnt),
    .out_y (sel_data)
  );

  // One-hot accept for the winner; nothing is accepted during reset.
  always_comb begin
    in_ready = '0;
    if (!rst && load_en && any_req) begin
      in_ready[gnt] = 1'b1;
    end
  end

  // The winner is always valid, so an accept is a transfer.
  assign xfer = !rst && load_en && any_req;

  // Output register, priority pointer and burst lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
`ifdef RR_ARB_BURST_LOCK_EN
      lock_vld  <= 1'b0;
      lock_idx  <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= gnt;
`ifdef RR_ARB_BURST_LOCK_EN
      if (in_last[gnt]) begin
        ptr      <= gnt + req_idx_t'(1);
        lock_vld <= 1'b0;
      end else begin
        lock_vld <= 1'b1;
        lock_idx <= gnt;
      end
`else
      ptr       <= gnt + req_idx_t'(1);
`endif
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_4x_nbit.sv
// Self-checking bench for rr_arb_4x_nbit: directed scenarios then random traffic.
// Reference model tracks pointer, output word and burst lock with plain integers.
// Build with RR_ARB_BURST_LOCK_EN defined to also exercise the burst lock.
module tb_rr_arb_4x_nbit;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_valid;
  logic [BW-1:0] dat [4];
  logic [3:0]    in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [1:0]    out_src;
`ifdef RR_ARB_BURST_LOCK_EN
  logic [3:0]    in_last;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int          m_ptr  = 0;
  bit          m_ovld = 1'b0;
  int          m_osrc = 0;
  logic [7:0]  m_odat = '0;
  bit          m_lock = 1'b0;
  int          m_lidx = 0;

  always #5 clk = ~clk;

  rr_arb_4x_nbit #(.BUS_WIDTH(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data_a (dat[0]),
    .in_data_b (dat[1]),
    .in_data_c (dat[2]),
    .in_data_d (dat[3]),
`ifdef RR_ARB_BURST_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Winner by the arbitration rules, -1 if nobody eligible.
  function automatic int model_winner(input logic [3:0] v);
    if (m_lock) return v[m_lidx] ? m_lidx : -1;
    for (int k = 0; k < 4; k++) begin
      if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  // One clock: drive inputs, check accept, clock, check the output register.
  // Without the burst feature every word counts as a last word.
  task automatic step(input logic r, input logic [3:0] v, input logic ordy, input logic [3:0] lst);
    int          w;
    bit          le;
    logic [31:0] exp_rdy;
    logic [3:0]  eff_last;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    out_ready = ordy;
`ifdef RR_ARB_BURST_LOCK_EN
    in_last   = lst;
    eff_last  = lst;
`else
    eff_last  = 4'hF;
`endif
    #1;
    le = !m_ovld || ordy;
    w  = model_winner(v);
    exp_rdy = '0;
    if (!r && le && w >= 0) exp_rdy = 32'(1) << w;
    check("in_ready", 32'(in_ready), exp_rdy);
    if (r) begin
      m_ovld = 1'b0; m_odat = '0; m_osrc = 0; m_ptr = 0; m_lock = 1'b0; m_lidx = 0;
    end else if (le) begin
      if (w >= 0) begin
        m_ovld = 1'b1;
        m_odat = dat[w];
        m_osrc = w;
        if (eff_last[w]) begin
          m_ptr  = (w + 1) % 4;
          m_lock = 1'b0;
        end else begin
          m_lock = 1'b1;
          m_lidx = w;
        end
      end else begin
        m_ovld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ovld));
    if (m_ovld || r) begin
      check("out_data", 32'(out_data), 32'(m_odat));
      check("out_src", 32'(out_src), 32'(m_osrc));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
`ifdef RR_ARB_BURST_LOCK_EN
    in_last = 4'hF;
`endif
    for (int i = 0; i < 4; i++) dat[i] = 8'h0A + 8'(i);

    // Reset with every requester asserting
    step(1'b1, 4'hF, 1'b1, 4'hF);
    step(1'b1, 4'hF, 1'b1, 4'hF);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_src", 32'(out_src), 32'd0);

    // Full load: strict rotation 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'hF, 1'b1, 4'hF);
      check("rot_src", 32'(out_src), 32'(i % 4));
      check("rot_data", 32'(out_data), 32'(8'h0A + 8'(i % 4)));
    end

    // Backpressure holds the word, release continues without a bubble
    step(1'b1, 4'hF, 1'b1, 4'hF);
    step(1'b0, 4'hF, 1'b1, 4'hF);
    step(1'b0, 4'hF, 1'b0, 4'hF);
    check("bp_data", 32'(out_data), 32'h0A);
    check("bp_rdy", 32'(in_ready), 32'd0);
    step(1'b0, 4'hF, 1'b1, 4'hF);
    check("bp_next", 32'(out_data), 32'h0B);
    check("bp_vld", 32'(out_valid), 32'd1);

    // Sparse requests and pointer wrap
    step(1'b1, 4'h0, 1'b1, 4'hF);
    step(1'b0, 4'b0100, 1'b1, 4'hF);
    check("sp_src2a", 32'(out_src), 32'd2);
    step(1'b0, 4'b0100, 1'b1, 4'hF);
    check("sp_src2b", 32'(out_src), 32'd2);
    step(1'b0, 4'b1001, 1'b1, 4'hF);
    check("sp_src3", 32'(out_src), 32'd3);
    step(1'b0, 4'b1001, 1'b1, 4'hF);
    check("sp_src0", 32'(out_src), 32'd0);

    // Reset while a word is pending
    step(1'b1, 4'hF, 1'b0, 4'hF);
    check("mid_rst_vld", 32'(out_valid), 32'd0);
    step(1'b0, 4'hF, 1'b1, 4'hF);
    check("mid_rst_src", 32'(out_src), 32'd0);

`ifdef RR_ARB_BURST_LOCK_EN
    // Burst lock: requester 1 holds the channel for three words
    step(1'b1, 4'h0, 1'b1, 4'hF);
    step(1'b0, 4'b0001, 1'b1, 4'hF);
    check("bl_pre", 32'(out_src), 32'd0);
    step(1'b0, 4'b0011, 1'b1, 4'b1101);
    check("bl_w0", 32'(out_src), 32'd1);
    step(1'b0, 4'b0011, 1'b1, 4'b1101);
    check("bl_w1", 32'(out_src), 32'd1);
    step(1'b0, 4'b0011, 1'b1, 4'b1111);
    check("bl_w2", 32'(out_src), 32'd1);
    step(1'b0, 4'b0011, 1'b1, 4'b1111);
    check("bl_after", 32'(out_src), 32'd0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      step(($urandom_range(0, 39) == 0), 4'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arb_4x_nbit.md
Name: rr_arb_4x_nbit

Overview:
- Round-robin arbiter and output register that share one BUS_WIDTH-bit output channel between four valid/ready requesters.
- Computes the grant, drives the select of a 4:1 data mux, and registers the winning word with its source index.
- Sits between four producer blocks and a single downstream consumer.

Parameters:
BUS_WIDTH, 8, width of each requester data word and of out_data

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  4  per-requester valid; bit i belongs to requester i
in_data_a  input  BUS_WIDTH  requester 0 data
in_data_b  input  BUS_WIDTH  requester 1 data
in_data_c  input  BUS_WIDTH  requester 2 data
in_data_d  input  BUS_WIDTH  requester 3 data
in_ready  output  4  per-requester accept; at most one bit high
out_valid  output  1  out_data holds a word
out_ready  input  1  consumer accepts
out_data  output  BUS_WIDTH  registered winning word
out_src  output  2  index of the requester that supplied out_data

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_src=0, priority pointer ptr=0.
- Load enable: load_en = !out_valid | out_ready.
- Grant selection (combinational): starting at index ptr, search ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first index with in_valid set wins (gnt, 2 bits). any_req = |in_valid.
- in_ready[i] = load_en & any_req & (gnt==i). All other bits are 0. in_ready must not depend on out_valid beyond load_en.
- Transfer for requester i occurs when in_valid[i] & in_ready[i]. On a transfer at an edge:
  - out_data <= selected data
  - out_src <= gnt
  - out_valid <= 1
  - ptr <= gnt+1 (mod 4; wraps 3->0)
- If load_en is true but no request is present: out_valid <= 0 and ptr is unchanged.
- If out_valid & !out_ready: out_data, out_src, out_valid and ptr hold, and in_ready=0.
- Throughput: 1 word per cycle when out_ready is held high. Latency: accepted input appears on out_data the next cycle.
- Fairness: with all four requesters continuously valid, grant order is 0,1,2,3,0,... No requester waits more than 3 transfers.
- Simultaneous drain and refill: a downstream accept and a new load in the same cycle is allowed.
- Reset mid-operation: a pending out word is discarded, ptr returns to 0, and in_ready is 0 during the reset cycle.
- in_valid changes while not granted are legal. The block does not require valid to be held.

Optional Feature:
Macro: RR_ARB_BURST_LOCK_EN
- Defined:
  - Adds input port in_last[3:0].
  - Once requester i transfers a word with in_last[i]=0, the grant locks to i.
  - While locked, other requesters get no in_ready until requester i transfers a word with in_last[i]=1.
  - ptr advances only on that last transfer.
  - Lock register clears on reset.
- Undefined: no in_last port; every word is arbitrated independently, as described above.

Decomposition:
- Package arb_pkg:
  - localparam NUM_REQ=4
  - localparam IDX_W=2
  - typedef req_idx_t (logic [IDX_W-1:0])
- Sub-module rr_pick4: pure combinational; inputs req[3:0], ptr[1:0]; outputs gnt[1:0], any.
- Data select reuses the team's existing mux_4x_nbit, instanced with BUS_WIDTH and sel=gnt.

Test Plan:
1. Reset: hold rst=1 with in_valid=4'hF -> out_valid=0, in_ready=0, out_src=0. After release, first grant is requester 0.
2. All requesters valid, out_ready=1, data a..d = 8'h0A,8'h0B,8'h0C,8'h0D -> out_src 0,1,2,3,0 on consecutive cycles, with out_data 0A,0B,0C,0D,0A.
3. Backpressure: out_ready=0 after the first word -> out_data stays 8'h0A, in_ready=0. Raise out_ready -> next word 8'h0B follows in the next cycle with no bubble.
4. Sparse requests: only in_valid[2] with ptr=3 -> wrap search grants 2, then ptr=3. Next, requesters 0 and 3 valid -> 3 wins, then ptr=0.
5. Reset mid-stream while out_valid=1 -> out_valid=0 the next cycle and ptr=0.
6. With RR_ARB_BURST_LOCK_EN: requester 1 sends 3 words with in_last 0,0,1 while requester 0 is valid throughout -> out_src 1,1,1, then 0.
